// File: rtl/serializer_arbiter.sv
`default_nettype none
// ============================================================================
// serializer_arbiter : round-robin front end sharing one serializer among
//                      REQ_NUM requesters; screens out counts <= 2.
// Revision: 1.0
// ============================================================================
module serializer_arbiter #(
  parameter int WIDTH   = 16,
  parameter int REQ_NUM = 4
) (
  input  logic                                    clk_i,
  input  logic                                    srst_i,
  input  logic [REQ_NUM-1:0][WIDTH-1:0]           req_data_i,
  input  logic [REQ_NUM-1:0][$clog2(WIDTH)-1:0]   req_mod_i,
  input  logic [REQ_NUM-1:0]                      req_val_i,
  output logic [REQ_NUM-1:0]                      req_ready_o,
  output logic [REQ_NUM-1:0]                      drop_o,
  output logic [WIDTH-1:0]                        ser_data_o,
  output logic [$clog2(WIDTH)-1:0]                ser_mod_o,
  output logic                                    ser_val_o,
  input  logic                                    ser_busy_i,
  output logic                                    grant_val_o,
  output logic [$clog2(REQ_NUM)-1:0]              grant_id_o
);

  localparam int MW   = $clog2(WIDTH);
  localparam int IDW  = $clog2(REQ_NUM);
  localparam int IDW1 = IDW + 1;
  localparam logic [IDW:0]    REQ_NUM_W = IDW1'(REQ_NUM);
  localparam logic [MW-1:0]   MIN_MOD   = MW'(2);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(REQ_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       last_ptr_q;
  logic [WIDTH-1:0]     ser_data_q;
  logic [MW-1:0]        ser_mod_q;
  logic                 grant_val_q;
  logic [IDW-1:0]       grant_id_q;
  logic [REQ_NUM-1:0]   drop_q;

  logic                 w_win_found;
  logic [IDW-1:0]       w_win_id;
  logic [IDW:0]         w_cand;
  logic [REQ_NUM-1:0]   w_win_onehot;
  logic                 w_accept;
  logic                 w_keep;

  // Search starts just after the last winner; the extra bit lets non-power-of-2
  // counts wrap by explicit subtraction.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_cand      = '0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      w_cand = {1'b0, last_ptr_q} + IDW1'(i);
      if (w_cand >= REQ_NUM_W) begin
        w_cand = w_cand - REQ_NUM_W;
      end
      if (!w_win_found && req_val_i[w_cand[IDW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_id    = w_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_win_onehot = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      w_win_onehot[k] = (IDW'(k) == w_win_id);
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    w_accept    = 1'b0;
    w_keep      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!srst_i && !ser_busy_i && w_win_found) begin
          w_accept    = 1'b1;
          req_ready_o = w_win_onehot;
          w_keep      = (req_mod_i[w_win_id] > MIN_MOD);
          if (w_keep) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!ser_busy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= S_IDLE;
      last_ptr_q  <= LAST_ID;
      ser_data_q  <= '0;
      ser_mod_q   <= '0;
      grant_val_q <= 1'b0;
      grant_id_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_val_q <= (state_d != S_IDLE);
      drop_q      <= '0;
      if (w_accept) begin
        last_ptr_q <= w_win_id;
        if (w_keep) begin
          ser_data_q <= req_data_i[w_win_id];
          ser_mod_q  <= req_mod_i[w_win_id];
          grant_id_q <= w_win_id;
        end else begin
          drop_q <= w_win_onehot;
        end
      end
    end
  end

  assign ser_val_o   = (state_q == S_ISSUE);
  assign ser_data_o  = ser_data_q;
  assign ser_mod_o   = ser_mod_q;
  assign drop_o      = drop_q;
  assign grant_val_o = grant_val_q;
  assign grant_id_o  = grant_id_q;

endmodule
`default_nettype wire

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin arbiter that shares one `serializer` instance among `REQ_NUM` independent requesters. Each requester offers a parallel word plus bit count over a valid/ready handshake. The arbiter grants one requester, screens out counts the serializer would ignore, and issues one `data_val_i` pulse. It holds further grants until the serializer's `busy_o` falls. It sits directly in front of the serializer, and its ser_* outputs wire straight to the serializer's inputs.

## Interface
- `WIDTH`, 16: parallel word width; must match the serializer.
- `REQ_NUM`, 4: number of requesters, ≥2.
- `clk_i` in 1: single clock; all logic on posedge.
- `srst_i` in 1: synchronous, active-high reset.
- `req_data_i` in [REQ_NUM-1:0][WIDTH-1:0]: per-requester word.
- `req_mod_i` in [REQ_NUM-1:0][$clog2(WIDTH)-1:0]: per-requester bit count.
- `req_val_i` in [REQ_NUM-1:0]: per-requester request valid; held until accepted.
- `req_ready_o` out [REQ_NUM-1:0]: one-hot accept. Transfer occurs when `req_val_i[k] & req_ready_o[k]`.
- `drop_o` out [REQ_NUM-1:0]: one-cycle pulse; accepted request discarded because its count was ≤2.
- `ser_data_o` out WIDTH: to serializer `data_i`.
- `ser_mod_o` out $clog2(WIDTH): to serializer `data_mod_i`.
- `ser_val_o` out 1: to serializer `data_val_i`; one-cycle pulse.
- `ser_busy_i` in 1: from serializer `busy_o`.
- `grant_val_o` out 1: a requester currently owns the serializer (ISSUE or WAIT).
- `grant_id_o` out $clog2(REQ_NUM): index of the owner; valid while `grant_val_o` is high.

## Operation
- **States**
  - IDLE: no grant in progress.
  - ISSUE: drive the serializer for one cycle.
  - WAIT: wait for the serializer to finish.
- **IDLE**
  - When `ser_busy_i`=0 and any `req_val_i` is high, select winner k by round-robin, then assert `req_ready_o[k]` combinationally in the same cycle.
  - When `ser_busy_i`=1, keep all `req_ready_o` low.
  - On the transfer cycle, register `req_data_i[k]`, `req_mod_i[k]` and k, and update `last_ptr` to k.
  - If `req_mod_i[k]` > 2, go to ISSUE.
  - Otherwise pulse `drop_o[k]` on the next cycle and stay in IDLE. No serializer activity occurs.
- **ISSUE**
  - `ser_val_o`=1 with the registered data and count.
  - Unconditionally go to WAIT.
- **WAIT**
  - `ser_val_o`=0.
  - When `ser_busy_i`=0 is sampled, go to IDLE.
  - The first WAIT cycle always sees busy=1, because the serializer raises busy one cycle after an accepted valid.
- **Round-robin**
  - Search order is `last_ptr+1`, `last_ptr+2`, … modulo REQ_NUM.
  - `last_ptr` resets to REQ_NUM-1, so requester 0 wins first.
  - Dropped transfers also advance `last_ptr`.
- **Output registers**
  - `ser_data_o` and `ser_mod_o` hold their last value outside ISSUE.
  - `req_ready_o` is never asserted outside IDLE.
- **Arithmetic**
  - Count comparison is unsigned on `$clog2(WIDTH)` bits.
  - The pointer wraps from REQ_NUM-1 to 0. Non-power-of-2 REQ_NUM must wrap explicitly.

## Timing
- **Reset values**
  - State IDLE, `last_ptr`=REQ_NUM-1.
  - `req_ready_o`=0, `drop_o`=0, `ser_val_o`=0, `ser_data_o`=0, `ser_mod_o`=0.
  - `grant_val_o`=0, `grant_id_o`=0.
  - `req_ready_o` is forced 0 while `srst_i`=1.
- **Accepted request, count m>2, transfer at cycle A**
  - `ser_val_o` at A+1.
  - Serializer busy covers A+2..A+1+m.
  - WAIT samples busy=0 at A+2+m.
  - IDLE at A+3+m; the earliest next transfer is at A+3+m.
- **Dropped request at cycle A**
  - `drop_o[k]` at A+1.
  - The next transfer can occur at A+1.
- **`grant_val_o`/`grant_id_o`**
  - Registered; high from A+1 through the last WAIT cycle.
- **Simultaneous requests**
  - Exactly one winner per IDLE transfer; losers keep `req_val_i` high and are served in round-robin order.
- **Reset mid-operation**
  - Any state returns to IDLE next cycle.
  - Registered request is lost, with no `drop_o`.
  - Serializer shares `srst_i`, so `ser_busy_i` is 0 after reset.
- **`ser_busy_i`=1 while in IDLE** (serializer driven elsewhere or not yet reset)
  - No grant until it falls.

## Test plan
- **Single request:** req 2 valid, data 16'hA5F0, mod 5 → `req_ready_o`=4'b0100 in the same cycle; `ser_val_o` one cycle later with 16'hA5F0/5; `grant_id_o`=2; next accept allowed 5+3 cycles after the transfer.
- **Contention:** all four `req_val_i` held high from reset → grant order 0,1,2,3,0, each starting only after `ser_busy_i` falls; no overlapping `ser_val_o`.
- **Drop:** req 1, mod 2 → `drop_o`=4'b0010 one cycle after transfer; `ser_val_o` stays 0; next requester 2 granted the following cycle.
- **Fairness after drop:** req 0 mod 1 (dropped), req 0 and 3 then valid → 3 granted before 0.
- **Reset in WAIT:** `srst_i` pulsed mid-serialization → next cycle state IDLE, `grant_val_o`=0, `last_ptr` back to REQ_NUM-1, and a pending req 0 is granted first.
- **External busy:** `ser_busy_i` forced 1 with req 3 valid → `req_ready_o` stays 0 until busy=0, then req 3 granted that cycle.
